// File: rtl/tick_timebase.sv
`default_nettype none
// ============================================================================
// Module  : tick_timebase
// Brief   : Programmable prescaler base tick with cascaded modulo stages.
// Revision: 1.0 - initial release
// ============================================================================
module tick_timebase #(
  parameter int CNT_W          = 32,
  parameter int PERIOD_DEFAULT = 50_000_000,
  parameter int NUM_STAGES     = 2,
  parameter int STAGE_DIV      = 60,
  parameter int STAGE_W        = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          period_we,
  input  logic [CNT_W-1:0]              period_wdata,
  output logic [NUM_STAGES:0]           ticks,
  output logic [NUM_STAGES*STAGE_W-1:0] stage_cnt,
  output logic                          sq_out
);

  localparam logic [CNT_W-1:0]   c_period_rst = (PERIOD_DEFAULT == 0) ? CNT_W'(1) : CNT_W'(PERIOD_DEFAULT);
  localparam logic [STAGE_W-1:0] c_stage_last = STAGE_W'(STAGE_DIV - 1);

  logic [CNT_W-1:0]              r_pcnt;
  logic [CNT_W-1:0]              r_period;
  logic [NUM_STAGES*STAGE_W-1:0] r_stage;
  logic [NUM_STAGES*STAGE_W-1:0] w_stage_nxt;
  logic [NUM_STAGES:0]           r_ticks;
  logic [NUM_STAGES:0]           w_evt;
  logic [NUM_STAGES-1:0]         w_wrap;
  logic                          r_sq;
  logic                          w_base;

  // r_period is never 0, so period-1 cannot underflow and pcnt never exceeds it
  assign w_base   = en && (r_pcnt == r_period - CNT_W'(1));
  assign w_evt[0] = w_base;

  genvar k;
  generate
    for (k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic [STAGE_W-1:0] w_cnt;
      assign w_cnt     = r_stage[k*STAGE_W +: STAGE_W];
      assign w_wrap[k] = (w_cnt == c_stage_last);
      // A level-(k+1) event needs the base event and every lower stage wrapping
      assign w_evt[k+1] = w_base & (&w_wrap[k:0]);
      assign w_stage_nxt[k*STAGE_W +: STAGE_W] =
        !w_evt[k] ? w_cnt : (w_wrap[k] ? '0 : w_cnt + STAGE_W'(1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcnt   <= '0;
      r_period <= c_period_rst;
      r_stage  <= '0;
      r_ticks  <= '0;
      r_sq     <= 1'b0;
    end else if (clr || period_we) begin
      r_pcnt  <= '0;
      r_ticks <= '0;
      if (period_we) begin
        r_period <= (period_wdata == '0) ? CNT_W'(1) : period_wdata;
      end
      if (clr) begin
        r_stage <= '0;
      end
    end else if (en) begin
      r_ticks <= w_evt;
      r_stage <= w_stage_nxt;
      if (w_base) begin
        r_pcnt <= '0;
        r_sq   <= ~r_sq;
      end else begin
        r_pcnt <= r_pcnt + CNT_W'(1);
      end
    end else begin
      r_ticks <= '0;
    end
  end

  assign ticks     = r_ticks;
  assign stage_cnt = r_stage;
  assign sq_out    = r_sq;

endmodule
`default_nettype wire

// File: tb/tb_tick_timebase.sv
`default_nettype none
// ============================================================================
// Module  : tb_tick_timebase
// Brief   : Scoreboard bench for tick_timebase (PERIOD_DEFAULT=4, 2 stages mod 3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tick_timebase;

  localparam int CNT_W = 8;
  localparam int NS    = 2;
  localparam int DIV   = 3;
  localparam int SW    = 2;
  localparam int PDEF  = 4;

  typedef struct packed {
    logic [NS:0]      t;
    logic [NS*SW-1:0] s;
    logic             sq;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             period_we = 1'b0;
  logic [CNT_W-1:0] period_wdata = '0;
  logic [NS:0]      ticks;
  logic [NS*SW-1:0] stage_cnt;
  logic             sq_out;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state of the timebase as the bench believes it should be
  int   m_pcnt, m_period, m_sq;
  int   m_s[NS];
  logic [NS:0] m_t;

  tick_timebase #(
    .CNT_W(CNT_W), .PERIOD_DEFAULT(PDEF), .NUM_STAGES(NS), .STAGE_DIV(DIV), .STAGE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .period_we(period_we),
    .period_wdata(period_wdata), .ticks(ticks), .stage_cnt(stage_cnt), .sq_out(sq_out)
  );

  always #5 clk = ~clk;

  task automatic model(input bit rn, input bit e, input bit c, input bit we, input int wd);
    bit carry;
    m_t = '0;
    if (!rn) begin
      m_pcnt = 0; m_period = PDEF; m_sq = 0;
      for (int i = 0; i < NS; i++) m_s[i] = 0;
    end else if (c || we) begin
      if (we) m_period = (wd == 0) ? 1 : wd;
      m_pcnt = 0;
      if (c) for (int i = 0; i < NS; i++) m_s[i] = 0;
    end else if (e) begin
      m_pcnt = m_pcnt + 1;
      if (m_pcnt == m_period) begin
        m_pcnt = 0;
        m_sq   = 1 - m_sq;
        m_t[0] = 1'b1;
        carry  = 1'b1;
        for (int i = 0; i < NS; i++) begin
          if (carry) begin
            m_s[i] = m_s[i] + 1;
            if (m_s[i] == DIV) begin
              m_s[i]   = 0;
              m_t[i+1] = 1'b1;
            end else begin
              carry = 1'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit rn, input bit e, input bit c, input bit we, input int wd);
    exp_t x;
    @(negedge clk);
    rst_n = rn; en = e; clr = c; period_we = we; period_wdata = CNT_W'(wd);
    model(rn, e, c, we, wd);
    x.t  = m_t;
    x.s  = {2'(m_s[1]), 2'(m_s[0])};
    x.sq = m_sq[0];
    sb.push_back(x);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0);
  endtask

  // Monitor: outputs are registered, so every cycle presents a new response
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ticks !== e.t) begin
        errors++;
        $display("FAIL ticks @%0t: got %b expected %b", $time, ticks, e.t);
      end
      checks++;
      if (stage_cnt !== e.s) begin
        errors++;
        $display("FAIL stage_cnt @%0t: got %h expected %h", $time, stage_cnt, e.s);
      end
      checks++;
      if (sq_out !== e.sq) begin
        errors++;
        $display("FAIL sq_out @%0t: got %b expected %b", $time, sq_out, e.sq);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int guard;
    // 1: reset then free-running count, through the first ticks[2] at 36
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    run(40);
    // 2: freeze after 2 enabled cycles, then resume
    cyc(0, 0, 0, 0, 0);
    run(2);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    run(6);
    // 3: period write of 2, one cycle after a tick
    guard = 0;
    while (!m_t[0] && guard < 20) begin
      run(1);
      guard++;
    end
    cyc(1, 1, 0, 1, 2);
    run(10);
    // 4: period write of 0 clamps to a continuous base tick
    cyc(1, 1, 0, 1, 0);
    run(20);
    // 5: clear on the cycle a base event would occur
    cyc(1, 1, 0, 1, 4);
    run(3);
    cyc(1, 1, 1, 0, 0);
    run(6);
    // 6: reset mid-count after a period change to 7; then reset beats clr/we
    cyc(1, 1, 0, 1, 7);
    run(3);
    cyc(0, 1, 0, 0, 0);
    run(6);
    cyc(0, 1, 1, 1, 9);
    run(6);
    // clr and period_we together, then full-scale period
    run(2);
    cyc(1, 1, 1, 1, 3);
    run(7);
    cyc(1, 1, 0, 1, 255);
    run(260);
    cyc(1, 0, 0, 0, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 5) begin
      @(posedge clk);
      #2;
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tick_timebase.md
Name: tick_timebase

Overview:
Parametrised timebase generator for the board's timekeeping logic. A programmable prescaler divides clk into a one-cycle base tick, at one second by default. A chain of cascaded modulo stages produces coincident higher-order ticks, e.g. minute and hour. Adds enable, synchronous clear, run-time period load, exposed stage counts and a 50% square wave. Ticks drive counters, display refresh and LED blink logic as clock enables, never as clocks.

Parameters:
CNT_W, 32, prescaler and period register width
PERIOD_DEFAULT, 50_000_000, base tick period in clk cycles after reset; must fit CNT_W
NUM_STAGES, 2, number of cascaded divide stages after the base tick
STAGE_DIV, 60, modulus of every cascade stage; must be >= 2
STAGE_W, 6, width of each stage count; must hold STAGE_DIV-1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  count enable; low freezes all counters
clr  in  1  synchronous clear of prescaler and stage counts
period_we  in  1  load period_wdata into period register
period_wdata  in  CNT_W  new base period in cycles
ticks  out  NUM_STAGES+1  ticks[0] base tick; ticks[k] stage k-1 wrap tick; each a one-cycle pulse
stage_cnt  out  NUM_STAGES*STAGE_W  packed stage counts; slice k is count of ticks[k] events, modulo STAGE_DIV
sq_out  out  1  toggles on every base tick

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous, active-low.
- Reset values (rst_n low at a clk edge): pcnt=0, all stage_cnt=0, ticks=0, sq_out=0, period_r=PERIOD_DEFAULT. Reset has highest priority and aborts any count in progress.
- Priority per edge: rst_n > clr/period_we > en counting.
- Prescaler: when en=1, pcnt increments. Base event when pcnt==period_r-1; pcnt then wraps to 0.
- Base period is exactly period_r cycles: the first ticks[0] pulse is visible after the period_r-th enabled edge following reset.
- All outputs are registered. ticks[0] is high for exactly one cycle per event.
- Stage k, for k=0..NUM_STAGES-1, counts level-k events. On a level-k event:
  - if stage_cnt[k]==STAGE_DIV-1: wrap to 0 and generate a level-(k+1) event in the same cycle;
  - else increment.
- ticks[k+1] is asserted in the same cycle as ticks[k]. stage_cnt updates in the same cycle the causing tick is visible.
- sq_out inverts in the cycle ticks[0] asserts, giving period 2*period_r at 50% duty.
- en=0: pcnt, stage_cnt and sq_out hold; ticks=0 next cycle. On resume, counting continues from the held pcnt; no cycles are lost or duplicated.
- clr=1: pcnt and stage_cnt go to 0; ticks=0 next cycle; sq_out and period_r are kept. A base event coinciding with clr is suppressed.
- period_we=1:
  - period_r loads period_wdata; a value of 0 is stored as 1.
  - pcnt resets to 0, and a coinciding base event is suppressed.
  - stage_cnt and sq_out are kept.
  - The next tick arrives after period_r enabled edges.
- period_r=1 (loaded or clamped): ticks[0] is high on every enabled cycle, a continuous level.
- clr and period_we together: both take effect.
- Full-scale period (all ones) must not overflow pcnt. The compare is width-safe at CNT_W.

Test Plan:
Params PERIOD_DEFAULT=4, NUM_STAGES=2, STAGE_DIV=3, STAGE_W=2 unless stated.
1. Reset, then en=1 held → ticks[0] pulses 4 cycles apart starting 4 edges after reset release; ticks[1] with every 3rd (at 12, 24); ticks[2] at 36 together with ticks[1] and ticks[0]; stage_cnt slice 0 cycles 1,2,0; sq_out period 8 cycles.
2. en=0 for 5 cycles after 2 enabled cycles, then en=1 → no ticks while low; first tick 2 enabled cycles after resume; stage_cnt unchanged during freeze.
3. period_we=1, wdata=2 one cycle after a tick → no tick in the write cycle; ticks[0] then every 2 cycles; stage_cnt preserved; sq_out period 4.
4. period_we=1, wdata=0 → ticks[0] high every enabled cycle; ticks[1] every 3rd cycle; ticks[2] every 9th cycle.
5. clr asserted on the cycle a base event would occur → no ticks[0]; stage_cnt=0; next ticks[0] 4 edges later; sq_out unchanged.
6. rst_n pulsed low mid-count after period changed to 7 → all outputs zero; period returns to 4; ticks[0] 4 edges after release. Check also rst_n low with clr and period_we high: reset wins, period=4.
